seg7_scan_driver: RTL

- Reads the four latched 5-bit display digits from the measurement result register and drives a 4-digit multiplexed 7-segment display.
- Uses time-multiplexed anode scanning, an anti-ghosting blank gap, leading-zero blanking and per-digit decimal point.
- Accepts a one-cycle load strobe from the counter control so that a new result is shown frame-coherently, with no torn display.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_decoder.sv | 36 +++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed 7-segment driver.
//   digit_t    : one display digit, decimal point in bit 4 and a 4-bit code below it.
//   CODE_*     : the non-numeric display codes.
//   SEG_*      : active-high segment patterns in gfedcba order (bit 0 = segment a).
package seg7_pkg;

  typedef struct packed {
    logic       dp;
    logic [3:0] code;
  } digit_t;

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_DASH  = 4'd11;
  localparam logic [3:0] CODE_E     = 4'd12;
  localparam logic [3:0] CODE_H     = 4'd13;
  localparam logic [3:0] CODE_L     = 4'd14;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_H    = 7'h76;
  localparam logic [6:0] SEG_L    = 7'h38;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational code-to-segment decoder.
//   code    : 4-bit display code (0-9 digits, 10/15 blank, 11 dash, 12 E, 13 H, 14 L).
//   blank   : forces all segments off (leading-zero blanking).
//   pattern : active-high segment pattern, gfedcba.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    if (!blank) begin
      case (code)
        4'd0:      pattern = SEG_0;
        4'd1:      pattern = SEG_1;
        4'd2:      pattern = SEG_2;
        4'd3:      pattern = SEG_3;
        4'd4:      pattern = SEG_4;
        4'd5:      pattern = SEG_5;
        4'd6:      pattern = SEG_6;
        4'd7:      pattern = SEG_7;
        4'd8:      pattern = SEG_8;
        4'd9:      pattern = SEG_9;
        CODE_DASH: pattern = SEG_DASH;
        CODE_E:    pattern = SEG_E;
        CODE_H:    pattern = SEG_H;
        CODE_L:    pattern = SEG_L;
        default:   pattern = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment display driver.
//   clk, reset            : system clock, synchronous active-high reset.
//   load                  : one-cycle strobe, digit3_in..digit0_in valid with it.
//   digit3_in..digit0_in  : {dp, code[3:0]} per digit, digit3 most significant.
//   an[3:0]               : anode enables, an[i] selects digit i.
//   seg[6:0], dp          : segments gfedcba and decimal point.
//   frame_tick            : one-cycle pulse the cycle after each frame wrap.
// Scanning runs digit 3 down to digit 0. Each slot starts with GHOST_GAP cycles
// of all anodes off. New digits are staged in a hold register and only copied
// to the displayed shadow at a frame boundary, so a frame is never torn.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned GHOST_GAP      = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] digit3_in,
  input  logic [4:0] digit2_in,
  input  logic [4:0] digit1_in,
  input  logic [4:0] digit0_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned   PW            = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GAP_END       = PW'(GHOST_GAP);

  logic [PW-1:0]  prescaler;
  logic [1:0]     idx;
  digit_t [3:0]   din;
  digit_t [3:0]   hold;
  digit_t [3:0]   shadow;
  logic           pending;
  logic           slot_end;
  logic           frame_end;

  digit_t         cur;
  logic           blank3, blank2, blank1;
  logic           cur_blank;
  logic [6:0]     pattern;
  logic [3:0]     an_next;
  logic [6:0]     seg_next;
  logic           dp_next;

  assign din[3] = digit3_in;
  assign din[2] = digit2_in;
  assign din[1] = digit1_in;
  assign din[0] = digit0_in;

  assign slot_end  = (prescaler == PRESCALE_LAST);
  assign frame_end = slot_end && (idx == 2'd0);

  // Prescaler, scan index (3..0, 2-bit wrap gives 0->3), frame pulse and the
  // hold/shadow handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      idx        <= 2'd3;
      hold       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      prescaler  <= slot_end ? '0 : prescaler + 1'b1;
      frame_tick <= frame_end;
      if (slot_end) begin
        idx <= idx - 2'd1;
      end
      // A load coinciding with the frame boundary bypasses hold so the new
      // value shows in the very next frame instead of one frame later.
      if (load) begin
        hold <= din;
        if (frame_end) begin
          shadow  <= din;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (frame_end && pending) begin
        shadow  <= hold;
        pending <= 1'b0;
      end
    end
  end

  // Leading-zero blanking: a digit is blanked only if it and every more
  // significant digit are zero without a decimal point.
  assign blank3 = (shadow[3].code == 4'd0) && !shadow[3].dp;
  assign blank2 = blank3 && (shadow[2].code == 4'd0) && !shadow[2].dp;
  assign blank1 = blank2 && (shadow[1].code == 4'd0) && !shadow[1].dp;

  assign cur = shadow[idx];

  always_comb begin
    cur_blank = 1'b0;
    case (idx)
      2'd3:    cur_blank = blank3;
      2'd2:    cur_blank = blank2;
      2'd1:    cur_blank = blank1;
      default: cur_blank = 1'b0;
    endcase
  end

  seg7_decoder u_decoder (
    .code    (cur.code),
    .blank   (cur_blank),
    .pattern (pattern)
  );

  always_comb begin
    an_next  = '0;
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    if (prescaler >= GAP_END) begin
      an_next  = 4'b0001 << idx;
      seg_next = pattern;
      dp_next  = cur.dp && !cur_blank;
    end
  end

  // Pin polarity is applied at the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {4{AN_ACTIVE_LOW}};
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
    end else begin
      an  <= an_next ^ {4{AN_ACTIVE_LOW}};
      seg <= seg_next ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_next ^ SEG_ACTIVE_LOW;
    end
  end

endmodule
